// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller with a frame-aligned display buffer.
// Supports blanking and leading-zero suppression. Outputs are registered and active-low.
module seg7_scan_ctrl #(
   parameter int PRESCALE = 100000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Load,
   input  logic [31:0] Data,
   input  logic        Blank,
   input  logic        LZB,
   output logic        Pending,
   output logic [6:0]  out7,
   output logic [7:0]  en_out
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pre;
   logic [2:0]    r_idx;
   logic [31:0]   r_shadow;
   logic [31:0]   r_disp;
   logic          r_pending;
   logic [6:0]    r_out7;
   logic [7:0]    r_en_out;

   logic          w_tick;
   logic          w_commit;
   logic [31:0]   w_upper;
   logic [3:0]    w_nib;
   logic          w_dark;
   logic [6:0]    w_glyph;

   // Active-high abcdefg pattern for one hex digit.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 7'b1111110;
         4'h1: glyph = 7'b0110000;
         4'h2: glyph = 7'b1101101;
         4'h3: glyph = 7'b1111001;
         4'h4: glyph = 7'b0110011;
         4'h5: glyph = 7'b1011011;
         4'h6: glyph = 7'b1011111;
         4'h7: glyph = 7'b1110000;
         4'h8: glyph = 7'b1111111;
         4'h9: glyph = 7'b1111011;
         4'hA: glyph = 7'b1110111;
         4'hB: glyph = 7'b0011111;
         4'hC: glyph = 7'b1001110;
         4'hD: glyph = 7'b0111101;
         4'hE: glyph = 7'b1001111;
         default: glyph = 7'b1000111;
      endcase
   endfunction

   always_comb begin
      w_tick   = (r_pre == PRE_MAX);
      w_commit = w_tick && (r_idx == 3'd7) && r_pending;
      // Digits at and above idx; zero means this digit is a leading zero.
      w_upper  = r_disp >> {r_idx, 2'b00};
      w_nib    = w_upper[3:0];
      w_dark   = Blank || (LZB && (r_idx != 3'd0) && (w_upper == 32'd0));
      w_glyph  = glyph(w_nib);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pre     <= '0;
         r_idx     <= 3'd0;
         r_shadow  <= 32'd0;
         r_disp    <= 32'd0;
         r_pending <= 1'b0;
         r_out7    <= 7'h7F;
         r_en_out  <= 8'hFF;
      end else begin
         if (w_tick) begin
            r_pre <= '0;
            r_idx <= r_idx + 3'd1;
         end else begin
            r_pre <= r_pre + PW'(1);
         end

         // A commit reads the old shadow; a same-cycle Load refills it and stays pending.
         if (w_commit)
            r_disp <= r_shadow;
         if (Load) begin
            r_shadow  <= Data;
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end

         if (w_dark) begin
            r_en_out <= 8'hFF;
            r_out7   <= 7'h7F;
         end else begin
            r_en_out <= ~(8'h01 << r_idx);
            r_out7   <= ~w_glyph;
         end
      end
   end

   assign Pending = r_pending;
   assign out7    = r_out7;
   assign en_out  = r_en_out;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic, compared
// cycle by cycle against a time-based reference model of the display.
module tb_seg7_scan_ctrl;

   localparam int P     = 4;
   localparam int FRAME = 8 * P;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Load = 1'b0;
   logic [31:0] Data = 32'd0;
   logic        Blank = 1'b0;
   logic        LZB = 1'b0;
   logic        Pending;
   logic [6:0]  out7;
   logic [7:0]  en_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: c counts clock edges since reset release.
   int          c = 0;
   logic [31:0] m_shadow = 32'd0;
   logic [31:0] m_disp = 32'd0;
   bit          m_pending = 1'b0;

   logic [6:0] glyph_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   seg7_scan_ctrl #(.PRESCALE(P)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .Data(Data), .Blank(Blank),
      .LZB(LZB), .Pending(Pending), .out7(out7), .en_out(en_out));

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input bit ld, input logic [31:0] d, input bit bl, input bit lz);
      int          idx;
      logic [31:0] up;
      bit          dark;
      bit          commit;
      logic [7:0]  exp_en;
      logic [6:0]  exp_o7;
      Load = ld; Data = d; Blank = bl; LZB = lz;
      idx  = (c / P) % 8;
      up   = m_disp >> (4 * idx);
      dark = bl || (lz && idx != 0 && up == 32'd0);
      exp_en = 8'hFF;
      if (!dark) exp_en[idx] = 1'b0;
      exp_o7 = dark ? 7'h7F : ~glyph_tab[up[3:0]];
      commit = ((c % P) == P - 1) && idx == 7 && m_pending;
      if (commit) begin
         m_disp    = m_shadow;
         m_pending = 1'b0;
      end
      if (ld) begin
         m_shadow  = d;
         m_pending = 1'b1;
      end
      @(posedge Clk);
      #1;
      check("en_out", {24'd0, en_out}, {24'd0, exp_en});
      check("out7", {25'd0, out7}, {25'd0, exp_o7});
      check("pending", {31'd0, Pending}, {31'd0, m_pending});
      c++;
      @(negedge Clk);
   endtask

   task automatic idle(input int n, input bit bl, input bit lz);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, bl, lz);
   endtask

   // Asserts reset between edges; outputs must clear without waiting for a clock.
   task automatic do_reset();
      Load = 1'b0;
      #2 Reset = 1'b1;
      #1;
      check("rst_en_out", {24'd0, en_out}, 32'hFF);
      check("rst_out7", {25'd0, out7}, 32'h7F);
      check("rst_pending", {31'd0, Pending}, 32'd0);
      @(posedge Clk);
      #1;
      check("rst_hold_en_out", {24'd0, en_out}, 32'hFF);
      @(negedge Clk);
      Reset = 1'b0;
      c = 0;
      m_shadow = 32'd0;
      m_disp = 32'd0;
      m_pending = 1'b0;
   endtask

   initial begin
      bit lz_r;
      #3;
      @(negedge Clk);
      do_reset();
      idle(2 * FRAME + 6, 1'b0, 1'b0);

      while ((c / P) % 8 != 2) idle(1, 1'b0, 1'b0);
      cycle(1'b1, 32'h89ABCDEF, 1'b0, 1'b0);
      idle(2 * FRAME + 10, 1'b0, 1'b0);

      cycle(1'b1, 32'h11111111, 1'b0, 1'b0);
      idle(5, 1'b0, 1'b0);
      cycle(1'b1, 32'h22222222, 1'b0, 1'b0);
      idle(2 * FRAME + 3, 1'b0, 1'b0);

      cycle(1'b1, 32'h44444444, 1'b0, 1'b0);
      while (c % FRAME != FRAME - 1) idle(1, 1'b0, 1'b0);
      cycle(1'b1, 32'h33333333, 1'b0, 1'b0);
      idle(2 * FRAME + 5, 1'b0, 1'b0);

      cycle(1'b1, 32'h00000A05, 1'b0, 1'b1);
      idle(2 * FRAME + 4, 1'b0, 1'b1);
      cycle(1'b1, 32'h00000000, 1'b0, 1'b1);
      idle(2 * FRAME + 4, 1'b0, 1'b1);

      cycle(1'b1, 32'h12345678, 1'b0, 1'b0);
      idle(FRAME + 13, 1'b0, 1'b0);
      idle(10, 1'b1, 1'b0);
      idle(FRAME + 7, 1'b0, 1'b0);

      cycle(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
      idle(5, 1'b0, 1'b0);
      do_reset();
      idle(FRAME + 9, 1'b0, 1'b0);

      lz_r = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] d;
         d = $urandom() >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) lz_r = ~lz_r;
         cycle($urandom_range(0, 19) == 0, d, $urandom_range(0, 7) == 0, lz_r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for the CPU's eight-digit seven-segment display: drives `out7` and `en_out` from a 32-bit value (eight hex digits). The CPU writes the value with a one-cycle load strobe. The value is double-buffered and committed only at scan-frame boundaries, so the display never tears. Each digit is lit for a fixed number of cycles, in turn. Optional blanking and leading-zero suppression are provided.

## Interface
- `PRESCALE`, default 100000: `Clk` cycles per digit slot; legal range 2..2^20.
- `Clk`  input  1  system clock; all state updates on rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `Load`  input  1  one-cycle strobe; captures `Data` into the shadow register.
- `Data`  input  32  display value; digit k = `Data[4k+3:4k]`, digit 0 is rightmost.
- `Blank`  input  1  when 1, all digits dark; scanning continues.
- `LZB`  input  1  when 1, leading-zero blanking is enabled.
- `Pending`  output  1  shadow holds a value not yet committed to the display.
- `out7`  output  7  segments {a,b,c,d,e,f,g}, active-low, registered.
- `en_out`  output  8  digit anodes, active-low, one-hot-low, registered; bit k is digit k.

## Operation
- State:
  - `pre` prescaler, width clog2(PRESCALE).
  - `idx` 3-bit digit index.
  - `shadow[31:0]`, `disp[31:0]`, `Pending`.
- Tick:
  - `tick` = (`pre` == PRESCALE-1). On tick, `pre` ← 0 and `idx` ← `idx`+1, wrapping 7→0. Otherwise `pre` increments.
- Load:
  - `Load`=1 → `shadow` ← `Data`, `Pending` ← 1.
  - A Load while `Pending`=1 overwrites `shadow`; the latest value wins.
- Commit:
  - Occurs on tick with `idx`==7 and `Pending`=1: `disp` ← `shadow`, `Pending` ← 0.
  - The next frame, starting at digit 0, shows the new value.
- Simultaneous Load and commit:
  - The commit takes the old `shadow`. The new `Data` goes to `shadow` and `Pending` stays 1.
- Digit nibble: `nib` = `disp[4*idx+3 : 4*idx]`.
- Glyphs, active-high abcdefg before inversion:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - `out7` = bitwise inverse of the glyph.
- Leading-zero blanking, with `LZB`=1:
  - Digit k is dark if `disp[31:4k]`==0 and k≠0.
  - Digit 0 is always lit, so value 0 shows a single "0".
- Output register, every cycle:
  - Dark (`Blank`=1 or LZB-suppressed) → `en_out` ← 8'hFF, `out7` ← 7'h7F.
  - Otherwise → `en_out` ← ~(8'h01 << `idx`), `out7` ← ~glyph(`nib`).
- `Blank` and `LZB` are sampled every cycle. They are not frame-aligned.

## Timing
- Reset values, applied immediately on `Reset`=1:
  - `pre`=0, `idx`=0, `shadow`=0, `disp`=0, `Pending`=0.
  - `out7`=7'h7F, `en_out`=8'hFF.
- Output latency:
  - Outputs lag `idx`/`disp`/`Blank`/`LZB` by exactly one cycle.
  - First rising edge after `Reset` falls: `en_out`=8'hFE, `out7`=7'h01 (digit 0 shows "0").
- Digit dwell: exactly PRESCALE cycles per digit; frame = 8·PRESCALE cycles.
- Load to display:
  - `Pending` rises the cycle after `Load`.
  - New value first appears at the digit-0 slot after the next 7→0 wrap, on the output one cycle later.
  - Worst case: 8·PRESCALE+1 cycles.
- Reset mid-frame:
  - Abandons the frame.
  - Drops any pending value; `shadow` is also cleared.
- No `Load` handshake/backpressure; `Load` is accepted every cycle.

## Test plan
- Reset/scan (PRESCALE=4, no Load, release Reset):
  - `en_out` cycles FE,FD,FB,…,7F, each held 4 cycles, then repeats.
  - `out7`=7'h01 throughout.
  - Reset asserted mid-frame → outputs 7F/FF the same cycle.
- Load commit (`Data`=32'h89ABCDEF during the digit-2 slot):
  - `Pending`=1 until the idx 7→0 wrap, then 0.
  - Next frame: digit 0 `out7`=7'h38 (F), digit 7 `out7`=7'h00 (8).
- Double load: `Data`=32'h11111111 then 32'h22222222 within one frame → only 2222_2222 displayed; digit 0 `out7`=7'h12.
- Collision: `Load` of 32'h33333333 exactly on the commit tick:
  - The older shadow value is displayed.
  - `Pending` stays 1.
  - 3333_3333 is shown one frame later.
- LZB (`disp`=32'h00000A05, `LZB`=1):
  - Digits 7..3 give `en_out`=FF.
  - Digits 2,1,0 lit with A(7'h08), 0(7'h01), 5(7'h24).
  - Value 0 → only digit 0 lit.
- Blank toggled mid-frame:
  - Outputs FF/7F from the next cycle.
  - `idx` and `pre` keep advancing.
  - On release, the same digit resumes at the correct phase.
